data_memory_lsu: RTL
====================

# data_memory_lsu

Parametrised successor to the 32-bit data memory. It is a single-port, word-organised RAM with RISC-V load/store semantics: byte, half and word access, sign or zero extension, byte-lane write masking and alignment fault detection. After every reset, a sequential clear engine zeroes the whole array before requests are accepted, so unwritten locations are guaranteed to read zero. The block sits behind the core's memory stage and is driven by a valid/ready request handshake.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, at least 4.
- `IDX_W`, `$clog2(DEPTH_WORDS)`: word index width (derived).
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 encoding.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `addr` in 32: byte address.
- `write_data` in 32: store data, taken from the low bits.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `rsp_valid` out 1: load response valid.
- `read_data` out 32: extended load result.
- `fault` out 1: misaligned or illegal request, reported with the response.
- `busy` out 1: clear engine running.

## Operation
- **FSM states:** CLEAR, READY.
  - `rst` forces CLEAR and sets `clr_idx` = 0.
  - In CLEAR, one word `mem[clr_idx]` is written to 0 per cycle.
  - After writing `DEPTH_WORDS-1`, the FSM moves to READY.
  - READY holds until the next `rst`.
- `req_ready` = (state == READY). `busy` = (state == CLEAR).
- **Word index:** `addr[IDX_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- **Store byte enables**, with `o = addr[1:0]`:
  - SB: lane `o`, data `write_data[7:0]`.
  - SH: lanes `o`, `o+1`, data `write_data[15:0]`.
  - SW: all lanes.
  - Unselected lanes are unchanged.
- **Load:** extract the byte or half at offset `o`. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
- **Fault conditions:**
  - Half access with `o[0]` = 1.
  - Word access with `o` != 0.
  - Load funct3 011, 110 or 111.
  - Store funct3 other than 000, 001, 010.
- **On fault:**
  - No array write.
  - For a load, `read_data` = 0, `rsp_valid` = 1, `fault` = 1.
  - For a faulting store, `fault` = 1 for the response cycle and `rsp_valid` = 0.
- **Stores** produce no `rsp_valid`.
- `fault` is 0 whenever no accepted request is being reported.
- Requests presented while `busy` are ignored: no write, no response.

## Timing
- **Reset values:**
  - `req_ready` = 0, `busy` = 1, `rsp_valid` = 0, `read_data` = 0, `fault` = 0.
  - These hold while `rst` is high.
- **Clear latency:** `req_ready` rises `DEPTH_WORDS` rising edges after `rst` falls.
- **Reset mid-clear or mid-request:**
  - Immediate return to CLEAR and restart from index 0.
  - A store in flight at the reset edge is not written.
- **Stores** commit at the rising edge of the accept cycle.
- **Default (combinational) mode:**
  - `rsp_valid`, `read_data` and `fault` are combinational in the accept cycle.
  - A load immediately after a store to the same word returns the new data.
- One request per cycle. Single port, so load and store cannot occur together.

## Configuration
- Macro: `DMEM_READ_REG_EN`.
- **Undefined:** combinational read path as above; load latency 0 cycles.
- **Defined:**
  - `rsp_valid`, `read_data` and `fault` are registered and appear one cycle after accept.
  - The registered outputs clear to 0 on `rst` and are 0 in cycles without an accepted load or fault.
  - `req_ready` is unchanged, giving full throughput.
  - A store followed next cycle by a load to the same word returns the stored value.

## Test plan
- **Clear after reset:** pulse `rst`, count cycles.
  - `req_ready` rises after exactly `DEPTH_WORDS` cycles.
  - LW of `0x00C` returns `0x00000000`.
- **Word and sub-word store:**
  - SW `0xDEADBEEF` at `0x004`, then SB `0x55` at `0x006`.
  - LW `0x004` returns `0xDE55BEEF`.
- **Sign and zero extension:** with `0xDE55BEEF` at `0x004`:
  - LB `0x007` returns `0xFFFFFFDE`; LBU `0x007` returns `0x000000DE`.
  - LH `0x004` returns `0xFFFFBEEF`; LHU `0x004` returns `0x0000BEEF`.
- **Misalignment:**
  - SW `0x12345678` at `0x009` gives `fault` = 1, and LW `0x008` still returns 0.
  - LH at `0x003` gives `fault` = 1, `read_data` = 0.
- **Busy and wrap:**
  - A request during CLEAR is ignored.
  - SW `0xA5A5A5A5` at `4*DEPTH_WORDS + 0x010` is then readable by LW at `0x010`.
- **Reset mid-clear:**
  - Assert `rst` at clear index 5, then release.
  - Full `DEPTH_WORDS`-cycle clear repeats.
  - A word written before the reset reads 0 afterwards.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Word-organised RISC-V load/store data memory with post-reset clear engine.
// Define DMEM_READ_REG_EN to register rsp_valid/read_data/fault (one-cycle load latency).
module data_memory_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] read_data,
  output logic        fault,
  output logic        busy
);
  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [1:0]        off;
  logic              accept, is_byte, is_half, is_word, f3_ok, flt, st_en;
  logic [3:0]        be;
  logic [31:0]       wdat, word, ext;
  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic              rv_c, flt_c;
  logic [31:0]       rd_c;
  logic              unused_addr;

  assign idx         = addr[IDX_W+1:2];
  assign off         = addr[1:0];
  assign unused_addr = ^addr[31:IDX_W+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + IDX_W'(1);
      if (clr_idx_q == '1) state_d = READY;
    end
  end

  always_comb begin
    req_ready = (state_q == READY);
    busy      = (state_q == CLEAR);
  end

  assign accept = req_valid && req_ready;

  // Unsigned load encodings (100/101) share the size of their signed twins but are loads only.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    is_word = 1'b0;
    f3_ok   = 1'b1;
    case (req_funct3)
      3'b000:  is_byte = 1'b1;
      3'b001:  is_half = 1'b1;
      3'b010:  is_word = 1'b1;
      3'b100:  begin is_byte = 1'b1; f3_ok = !req_we; end
      3'b101:  begin is_half = 1'b1; f3_ok = !req_we; end
      default: f3_ok = 1'b0;
    endcase
    flt = !f3_ok || (is_half && off[0]) || (is_word && (off != 2'b00));
  end

  always_comb begin
    be   = 4'b1111;
    wdat = write_data;
    if (is_byte) begin
      be   = 4'b0001 << off;
      wdat = {4{write_data[7:0]}};
    end else if (is_half) begin
      be   = 4'b0011 << off;
      wdat = {2{write_data[15:0]}};
    end
  end

  assign st_en = accept && req_we && !flt;

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_idx_q] <= '0;
    end else if (st_en) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
    end
  end

  assign word = mem[idx];
  assign bsel = word[{off, 3'b000} +: 8];
  assign hsel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    ext = '0;
    case (req_funct3)
      3'b000:  ext = {{24{bsel[7]}}, bsel};
      3'b001:  ext = {{16{hsel[15]}}, hsel};
      3'b010:  ext = word;
      3'b100:  ext = {24'd0, bsel};
      3'b101:  ext = {16'd0, hsel};
      default: ext = '0;
    endcase
  end

  assign rv_c  = accept && !req_we;
  assign flt_c = accept && flt;
  assign rd_c  = (rv_c && !flt) ? ext : '0;

`ifdef DMEM_READ_REG_EN
  logic        rsp_valid_q, fault_q;
  logic [31:0] read_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      read_data_q <= '0;
    end else begin
      rsp_valid_q <= rv_c;
      fault_q     <= flt_c;
      read_data_q <= rd_c;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign fault     = fault_q;
  assign read_data = read_data_q;
`else
  assign rsp_valid = rv_c;
  assign fault     = flt_c;
  assign read_data = rd_c;
`endif

endmodule
